// File: rtl/trng_collector.sv
// trng_collector: packs raw TRNG bits into W-bit words behind a valid/ready port,
// with a sticky repetition-count health test. Define TRNG_VN_DEBIAS_EN for von Neumann debiasing.
module trng_collector #(
    parameter int W         = 32,
    parameter int REP_LIMIT = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         rand_in,
    input  logic         clr_fail,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         health_fail,
    output logic [1:0]   dbg_state
);
    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    REP_MAX  = 8'(REP_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t        state;
    logic [W-1:0]  shifter;
    logic [CW-1:0] bit_cnt;
    logic [7:0]    rep_cnt;
    logic [7:0]    rep_next;
    logic          prev_bit;
    logic          acc_valid;
    logic          acc_bit;
    logic          xfer;
    logic          word_done;
    logic [W-1:0]  shift_next;

    // Handshake: a word moves on any rising edge with out_valid=1 and out_ready=1;
    // out_valid/out_data hold until then, and out_ready may change freely.
    assign xfer       = out_valid && out_ready;
    assign shift_next = {shifter[W-2:0], acc_bit};
    assign word_done  = acc_valid && (bit_cnt == LAST_BIT);
    assign dbg_state  = state;

    // A run length of 0 means no previous sample, so the next sample starts a run of 1.
    always_comb begin
        rep_next = 8'd1;
        if (rep_cnt != 8'd0 && rand_in == prev_bit)
            rep_next = (rep_cnt == REP_MAX) ? REP_MAX : rep_cnt + 8'd1;
    end

`ifdef TRNG_VN_DEBIAS_EN
    logic pair_full;
    logic pair_bit;

    always_ff @(posedge clk) begin
        if (!rst || state == S_FAIL) begin
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
        end else if (en) begin
            pair_full <= !pair_full;
            pair_bit  <= rand_in;
        end
    end

    // (0,1) -> 0 and (1,0) -> 1: the accepted bit is the first of a differing pair.
    assign acc_valid = en && pair_full && (pair_bit != rand_in);
    assign acc_bit   = pair_bit;
`else
    assign acc_valid = en;
    assign acc_bit   = rand_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            health_fail <= 1'b0;
            shifter     <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            prev_bit    <= 1'b0;
        end else if (state == S_FAIL) begin
            if (clr_fail) begin
                health_fail <= 1'b0;
                rep_cnt     <= '0;
                state       <= en ? S_FILL : S_IDLE;
            end
        end else if (en && rep_next == REP_MAX) begin
            state       <= S_FAIL;
            health_fail <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            shifter     <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= rep_next;
            prev_bit    <= rand_in;
        end else begin
            if (en) begin
                rep_cnt  <= rep_next;
                prev_bit <= rand_in;
            end
            if (state == S_FULL) begin
                // Accepted bits are dropped while a finished word waits here.
                if (xfer) begin
                    out_data <= shifter;
                    shifter  <= '0;
                    state    <= S_FILL;
                end
            end else begin
                if (en)
                    state <= S_FILL;
                if (word_done) begin
                    if (!out_valid || out_ready) begin
                        out_data  <= shift_next;
                        out_valid <= 1'b1;
                        shifter   <= '0;
                    end else begin
                        shifter <= shift_next;
                        state   <= S_FULL;
                    end
                    bit_cnt <= '0;
                end else begin
                    if (acc_valid) begin
                        shifter <= shift_next;
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                    if (xfer)
                        out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: table-driven and hand-written sequences for trng_collector (W=8),
// with a word scoreboard checked at every output transfer.
module tb_trng_collector;
    localparam int W = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         rand_in = 1'b0;
    logic         clr_fail = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         health_fail;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] bits;
        logic [W-1:0] exp_data;
    } vec_t;
    vec_t vecs[7];

    trng_collector #(.W(W), .REP_LIMIT(32)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .rand_in(rand_in),
        .clr_fail(clr_fail),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .health_fail(health_fail),
        .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step(input logic e, input logic b);
        en = e;
        rand_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic feed_acc(input logic b);
`ifdef TRNG_VN_DEBIAS_EN
        step(1'b1, b);
        step(1'b1, ~b);
`else
        step(1'b1, b);
`endif
    endtask

    task automatic feed_word(input logic [W-1:0] w, input bit push);
        if (push)
            exp_q.push_back(w);
        for (int i = W - 1; i >= 0; i--)
            feed_acc(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b1;
    endtask

    // scoreboard: a transfer happens on the coming edge when valid and ready are both high
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL xfer_unexpected actual=%0h expected=none", out_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("xfer_data", 64'(out_data), 64'(e));
            end
        end
    end

    initial begin
        vecs[0] = '{bits: 8'hB2, exp_data: 8'hB2};
        vecs[1] = '{bits: 8'h3C, exp_data: 8'h3C};
        vecs[2] = '{bits: 8'hA5, exp_data: 8'hA5};
        vecs[3] = '{bits: 8'h81, exp_data: 8'h81};
        vecs[4] = '{bits: 8'h7E, exp_data: 8'h7E};
        vecs[5] = '{bits: 8'h0F, exp_data: 8'h0F};
        vecs[6] = '{bits: 8'hC9, exp_data: 8'hC9};

        do_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_health", 64'(health_fail), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // table vectors, first accepted bit lands in the MSB
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            feed_word(vecs[v].bits, 1'b1);
            check("vec_valid", 64'(out_valid), 64'd1);
            check("vec_data", 64'(out_data), 64'(vecs[v].exp_data));
        end
        idle(2);
        check("vec_drained", 64'(out_valid), 64'd0);

        // repetition-count health test
        do_reset();
`ifndef TRNG_VN_DEBIAS_EN
        for (int i = 0; i < 3; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'hFF);
`endif
        for (int i = 0; i < 31; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("rep_31_ok", 64'(health_fail), 64'd0);
        for (int i = 0; i < 31; i++) step(1'b1, 1'b1);
        check("rep_limit_minus1", 64'(health_fail), 64'd0);
        step(1'b1, 1'b1);
        check("rep_fail_flag", 64'(health_fail), 64'd1);
        check("rep_fail_valid", 64'(out_valid), 64'd0);
        check("rep_fail_data", 64'(out_data), 64'd0);
        check("rep_fail_state", 64'(dbg_state), 64'(ST_FAIL));
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
        check("fail_sticky", 64'(health_fail), 64'd1);
        check("fail_no_output", 64'(out_valid), 64'd0);
        clr_fail = 1'b1;
        step(1'b1, 1'b1);
        clr_fail = 1'b0;
        check("clr_health", 64'(health_fail), 64'd0);
        check("clr_state", 64'(dbg_state), 64'(ST_FILL));
        feed_word(8'h96, 1'b1);
        check("post_clr_data", 64'(out_data), 64'(8'h96));
        idle(2);

        // en gap mid-word, with a stray clr_fail outside FAIL
        exp_q.push_back(8'h6C);
        for (int i = 7; i >= 4; i--) feed_acc(1'(8'h6C >> i));
        clr_fail = 1'b1;
        step(1'b0, 1'b1);
        clr_fail = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("stray_clr_health", 64'(health_fail), 64'd0);
        for (int i = 3; i >= 0; i--) feed_acc(1'(8'h6C >> i));
        check("en_gap_data", 64'(out_data), 64'(8'h6C));
        check("en_gap_valid", 64'(out_valid), 64'd1);
        idle(2);

        // backpressure: third word is dropped while the second is held
        do_reset();
        out_ready = 1'b0;
        feed_word(8'hA3, 1'b1);
        feed_word(8'h5C, 1'b1);
        feed_word(8'hE7, 1'b0);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_data", 64'(out_data), 64'(8'hA3));
        check("bp_state", 64'(dbg_state), 64'(ST_FULL));
        idle(3);
        check("bp_stable", 64'(out_data), 64'(8'hA3));
        out_ready = 1'b1;
        step(1'b0, 1'b0);
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_second_data", 64'(out_data), 64'(8'h5C));
        step(1'b0, 1'b0);
        check("bp_drained", 64'(out_valid), 64'd0);
        feed_word(8'h1E, 1'b1);
        check("bp_restart_data", 64'(out_data), 64'(8'h1E));
        idle(2);

        // reset mid-word discards partial bits
        for (int i = 0; i < 5; i++) feed_acc(1'($urandom_range(0, 1)));
        rst = 1'b0;
        step(1'b1, 1'b1);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        check("midrst_health", 64'(health_fail), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b1;
        feed_word(8'hB2, 1'b1);
        check("midrst_word", 64'(out_data), 64'(8'hB2));
        idle(2);

`ifdef TRNG_VN_DEBIAS_EN
        // raw pairs 01,10,00,11 repeated: accepted 0,1 per repetition
        exp_q.push_back(8'h55);
        for (int r = 0; r < 4; r++) begin
            step(1'b1, 1'b0); step(1'b1, 1'b1);
            step(1'b1, 1'b1); step(1'b1, 1'b0);
            step(1'b1, 1'b0); step(1'b1, 1'b0);
            step(1'b1, 1'b1); step(1'b1, 1'b1);
        end
        check("vn_data", 64'(out_data), 64'(8'h55));
        check("vn_valid", 64'(out_valid), 64'd1);
        idle(2);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
